tristate_bus_responder: RTL and testbench
=========================================

# tristate_bus_responder

- Responder end of a shared, half-duplex, tri-state parallel bus.
- An external initiator either drives a word onto the bus for capture (write) or requests a word that this block drives back (read).
- The block owns its drive-enable.
- It enforces turnaround cycles with the bus released before and after every drive, so it never contends with the initiator.
- It sits between the bus pad and the local register/data logic.

## Interface

Parameters:

- WIDTH, 8 — bus and data word width in bits.
- TURN, 1 — turnaround cycles (0..3) with the bus released, before and after each drive.

Ports:

- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — reset; synchronous, active-high.
- bus  inout  WIDTH  — shared tri-state bus; driven only while oe=1, otherwise high-Z on every bit.
- req  input  1  — initiator transaction request, sampled each rising edge.
- rnw  input  1  — direction, sampled with req: 1 = initiator reads (block drives), 0 = initiator writes (block captures).
- rd_data  input  WIDTH  — local word to return on a read; latched when the request is accepted.
- wr_data  output  WIDTH  — last captured write word.
- wr_valid  output  1  — one-cycle pulse when wr_data is updated.
- ack  output  1  — one-cycle acknowledge, for both read and write.
- oe  output  1  — bus drive enable, visible for debug/pad use.
- busy  output  1  — high in every state except IDLE.

## Operation

States and transitions:

- IDLE
  - req=1, rnw=0 → stays in IDLE.
    - bus is captured into wr_data at that edge.
    - wr_valid=1 and ack=1 in the following cycle.
  - req=1, rnw=1 → rd_data is latched into the drive register.
    - Go to TURN_IN, or straight to DRIVE when TURN=0.
- TURN_IN — oe=0; counts TURN cycles, then DRIVE.
- DRIVE — exactly one cycle.
  - oe=1, bus = latched word, ack=1.
  - Then RELEASE, or IDLE when TURN=0.
- RELEASE — oe=0; counts TURN cycles, then IDLE.

Rules:

- req while busy=1 is ignored and not queued. The initiator must hold or re-issue req after busy falls.
- rd_data changes after acceptance do not affect the driven word.
- Capture is raw: X/Z bits on the bus are stored as sampled, with no filtering.
- The turnaround counter is 2 bits wide. It loads TURN-1 on state entry and exits on 0.
- The bus is high-Z whenever oe=0, with no partial-bit drive.
- Consecutive writes may be accepted on back-to-back cycles. Each produces its own wr_valid/ack pulse.

## Timing

Reset (rst=1 at an edge) puts the block in IDLE with:

- oe=0 (bus high-Z from the next cycle)
- ack=0, wr_valid=0, busy=0
- wr_data=0, drive register=0

Reset mid-DRIVE or mid-turnaround aborts the transaction: no ack and no further drive.

Read accepted at edge k:

- TURN_IN occupies cycles k+1 .. k+TURN.
- DRIVE (oe=1, ack=1) occupies cycle k+TURN+1.
- RELEASE occupies cycles k+TURN+2 .. k+2·TURN+1.
- busy falls and a new req is accepted at edge k+2·TURN+2.
- For TURN=0: drive at k+1, new req accepted at edge k+2.

Write accepted at edge k:

- wr_data, wr_valid and ack are valid during cycle k+1.
- busy stays 0.

Other cycle-level rules:

- ack and wr_valid are registered and never high for more than one cycle per transaction.
- oe is registered and glitch-free: it is asserted only in DRIVE.

## Structure

- Shared package tristate_bus_pkg holds:
  - the state enum (IDLE, TURN_IN, DRIVE, RELEASE);
  - the constant TURN_MAX=3;
  - the turnaround counter width (2).
- Sub-module tristate_pad (parameter WIDTH; ports oe, dout, pad inout, din) isolates the inout assignment.
  - Output: pad = oe ? dout : all-Z.
  - Input: din = pad.
- The FSM, counter and registers live in the top.

## Test plan

1. Reset: assert rst for 2 cycles mid-DRIVE (TURN=1, rd_data=8'hA5) → next cycle oe=0, bus === 8'hzz, ack=0, busy=0, wr_data=8'h00.
2. Write: bench drives bus=8'h3C with req=1, rnw=0 for one edge → next cycle wr_data=8'h3C, wr_valid=1, ack=1; oe=0 throughout.
3. Read, TURN=1: req=1, rnw=1, rd_data=8'h5A at edge k.
   - bus === 8'hzz at k+1.
   - bus=8'h5A with ack=1 at k+2.
   - bus === 8'hzz at k+3.
   - New req accepted at edge k+4.
4. Read, TURN=0: rd_data=8'hFF → bus=8'hFF and ack=1 at k+1; idle at k+2.
   - Separately, rd_data changed to 8'h00 after acceptance (TURN=1) → driven word is still the value latched at acceptance.
5. Busy/back-to-back:
   - A read at k, then write requests during k+1..k+3 (TURN=1) → ignored: no wr_valid, wr_data unchanged.
   - Two writes 8'h11 and 8'h22 on consecutive edges → two wr_valid pulses carrying 8'h11 then 8'h22.
6. Contention check, every TURN value 0..3: a bench monitor asserts the bench never drives while oe=1 → zero contention events.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// Shared types and constants for the tri-state bus responder.
// The turnaround counter width bounds how many released cycles a transaction can request.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN_IN = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int TURN_MAX = 3;
    localparam int CNT_W    = 2;

    // Load value for the turnaround counter: it counts down to zero, so TURN cycles need TURN-1.
    function automatic logic [CNT_W-1:0] turn_load(input int turn);
        if (turn <= 0) begin
            return '0;
        end
        if (turn > TURN_MAX) begin
            return CNT_W'(TURN_MAX - 1);
        end
        return CNT_W'(turn - 1);
    endfunction

endpackage

// File: rtl/tristate_bus_responder_pad.sv
// Pad wrapper: the only place the shared bus is driven, so tri-state handling stays in one spot.
module tristate_pad #(
    parameter int WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] dout,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] din
);

    assign pad = oe ? dout : {WIDTH{1'bz}};
    assign din = pad;

endmodule

// File: rtl/tristate_bus_responder.sv
// Responder end of a half-duplex tri-state bus: captures initiator writes and answers reads
// with a single drive cycle framed by released turnaround cycles.
module tristate_bus_responder
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             req,
    input  logic             rnw,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] wr_data,
    output logic             wr_valid,
    output logic             ack,
    output logic             oe,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = turn_load(TURN);
    localparam bit               HAS_TURN = (TURN > 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   drv_q, drv_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic               wr_valid_q, wr_valid_d;
    logic               ack_q, ack_d;
    logic               oe_q, oe_d;
    logic [WIDTH-1:0]   din;
    logic               wr_acc;
    logic               rd_acc;

    tristate_pad #(
        .WIDTH (WIDTH)
    ) u_pad (
        .oe   (oe_q),
        .dout (drv_q),
        .pad  (bus),
        .din  (din)
    );

    // Requests are only seen in IDLE; anything arriving while busy is dropped, not queued.
    assign wr_acc = (state_q == IDLE) && req && !rnw;
    assign rd_acc = (state_q == IDLE) && req && rnw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drv_q      <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drv_q      <= drv_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    cnt_d = CNT_LOAD;
                    if (HAS_TURN) begin
                        state_d = TURN_IN;
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            TURN_IN: begin
                if (cnt_q == '0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRIVE: begin
                cnt_d = CNT_LOAD;
                if (HAS_TURN) begin
                    state_d = RELEASE;
                end else begin
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flags are computed from the next state so oe/ack come straight off flops with no decode glitches.
    always_comb begin
        oe_d       = (state_d == DRIVE);
        ack_d      = wr_acc || (state_d == DRIVE);
        wr_valid_d = wr_acc;
        wr_data_d  = wr_acc ? din : wr_data_q;
        drv_d      = rd_acc ? rd_data : drv_q;
    end

    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign ack      = ack_q;
    assign oe       = oe_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_tristate_bus_responder.sv
// Bench for tristate_bus_responder: one instance per TURN value 0..3, directed scenarios plus
// randomized traffic checked against a cycle-timeline model of each transaction.
module tb_tristate_bus_responder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]      req, rnw, tb_en;
    logic [N-1:0][7:0] rd_data, tb_dat;
    wire  [N-1:0][7:0] wr_data_o, bus_obs;
    wire  [N-1:0]      wr_valid_o, ack_o, oe_o, busy_o;

    int checks = 0;
    int errors = 0;
    int contention = 0;

    // Timeline model: edges are numbered; the cycle after edge e is cycle e+1.
    int ed = 0;
    int free_at [N];
    int drive_at[N];
    int wr_at   [N];
    logic [7:0] m_drv[N];
    logic [7:0] m_wr [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gi
        wire [7:0] bus;
        assign bus        = tb_en[g] ? tb_dat[g] : 8'hzz;
        assign bus_obs[g] = bus;
        tristate_bus_responder #(
            .WIDTH (8),
            .TURN  (g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .req      (req[g]),
            .rnw      (rnw[g]),
            .rd_data  (rd_data[g]),
            .wr_data  (wr_data_o[g]),
            .wr_valid (wr_valid_o[g]),
            .ack      (ack_o[g]),
            .oe       (oe_o[g]),
            .busy     (busy_o[g])
        );
    end

    always @(negedge clk) contention <= contention + $countones(tb_en & oe_o);

    function automatic bit exp_oe(int g);
        return (ed + 1 == drive_at[g]);
    endfunction

    function automatic bit exp_wrv(int g);
        return (ed + 1 == wr_at[g]);
    endfunction

    function automatic bit exp_busy(int g);
        return (ed + 1 < free_at[g]);
    endfunction

    task automatic step();
        @(posedge clk);
        ed++;
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                free_at[g]  = ed + 1;
                drive_at[g] = -1;
                wr_at[g]    = -1;
                m_wr[g]     = 8'h00;
            end else if (req[g] && ed >= free_at[g]) begin
                if (rnw[g]) begin
                    m_drv[g]    = rd_data[g];
                    drive_at[g] = ed + g + 1;
                    free_at[g]  = ed + 2 * g + 2;
                end else begin
                    m_wr[g]  = tb_dat[g];
                    wr_at[g] = ed + 1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        req = '0; rnw = '0; tb_en = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; rnw = '0; tb_en = '0; rd_data = '0; tb_dat = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req[1] = 1'b1; rnw[1] = 1'b1; rd_data[1] = 8'hA5;
        step();
        req[1] = 1'b0;
        step();
        checks++;
        if (oe_o[1] !== 1'b1 || bus_obs[1] !== 8'hA5) begin
            errors++;
            $display("FAIL reset_pre_drive oe=%b bus=%h expected oe=1 bus=a5", oe_o[1], bus_obs[1]);
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (oe_o[g] !== 1'b0 || ack_o[g] !== 1'b0 || busy_o[g] !== 1'b0 ||
                wr_valid_o[g] !== 1'b0 || wr_data_o[g] !== 8'h00) begin
                errors++;
                $display("FAIL reset_state g=%0d oe=%b ack=%b busy=%b wrv=%b wr_data=%h expected all zero",
                         g, oe_o[g], ack_o[g], busy_o[g], wr_valid_o[g], wr_data_o[g]);
            end
        end
        tb_en = '1; tb_dat = '0;
        #1;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (bus_obs[g] !== 8'h00) begin
                errors++;
                $display("FAIL reset_bus_released g=%0d bus=%h expected bench probe 00", g, bus_obs[g]);
            end
        end
        tb_en = '0;
        step();
        checks++;
        if (ack_o[1] !== 1'b0 || oe_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort ack=%b oe=%b expected 0 0", ack_o[1], oe_o[1]);
        end
    endtask

    task automatic test_write();
        do_reset();
        tb_en = '1; tb_dat = {N{8'h3C}}; req = '1; rnw = '0;
        step();
        tb_en = '0; req = '0;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (wr_data_o[g] !== 8'h3C || wr_valid_o[g] !== 1'b1 || ack_o[g] !== 1'b1 ||
                oe_o[g] !== 1'b0 || busy_o[g] !== 1'b0) begin
                errors++;
                $display("FAIL write_capture g=%0d wr_data=%h wrv=%b ack=%b oe=%b busy=%b expected 3c 1 1 0 0",
                         g, wr_data_o[g], wr_valid_o[g], ack_o[g], oe_o[g], busy_o[g]);
            end
        end
        step();
        for (int g = 0; g < N; g++) begin
            checks++;
            if (wr_valid_o[g] !== 1'b0 || ack_o[g] !== 1'b0 || wr_data_o[g] !== 8'h3C) begin
                errors++;
                $display("FAIL write_pulse_end g=%0d wrv=%b ack=%b wr_data=%h expected 0 0 3c",
                         g, wr_valid_o[g], ack_o[g], wr_data_o[g]);
            end
        end
    endtask

    task automatic test_read_turn1();
        do_reset();
        req[1] = 1'b1; rnw[1] = 1'b1; rd_data[1] = 8'h5A;
        step();
        req[1] = 1'b0; rd_data[1] = 8'h00;
        tb_en[1] = 1'b1; tb_dat[1] = 8'h00;
        #1;
        checks++;
        if (oe_o[1] !== 1'b0 || busy_o[1] !== 1'b1 || bus_obs[1] !== 8'h00) begin
            errors++;
            $display("FAIL read1_turn_in oe=%b busy=%b bus=%h expected 0 1 probe 00", oe_o[1], busy_o[1], bus_obs[1]);
        end
        tb_en[1] = 1'b0;
        step();
        checks++;
        if (oe_o[1] !== 1'b1 || ack_o[1] !== 1'b1 || bus_obs[1] !== 8'h5A) begin
            errors++;
            $display("FAIL read1_drive oe=%b ack=%b bus=%h expected 1 1 5a", oe_o[1], ack_o[1], bus_obs[1]);
        end
        step();
        tb_en[1] = 1'b1; tb_dat[1] = 8'h00;
        #1;
        checks++;
        if (oe_o[1] !== 1'b0 || ack_o[1] !== 1'b0 || busy_o[1] !== 1'b1 || bus_obs[1] !== 8'h00) begin
            errors++;
            $display("FAIL read1_release oe=%b ack=%b busy=%b bus=%h expected 0 0 1 probe 00",
                     oe_o[1], ack_o[1], busy_o[1], bus_obs[1]);
        end
        tb_dat[1] = 8'h77; req[1] = 1'b1; rnw[1] = 1'b0;
        step();
        checks++;
        if (wr_valid_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL read1_busy_ignore wrv=%b busy=%b expected 0 0", wr_valid_o[1], busy_o[1]);
        end
        step();
        req[1] = 1'b0; tb_en[1] = 1'b0;
        checks++;
        if (wr_valid_o[1] !== 1'b1 || ack_o[1] !== 1'b1 || wr_data_o[1] !== 8'h77) begin
            errors++;
            $display("FAIL read1_next_accept wrv=%b ack=%b wr_data=%h expected 1 1 77",
                     wr_valid_o[1], ack_o[1], wr_data_o[1]);
        end
    endtask

    task automatic test_read_turn0();
        do_reset();
        req[0] = 1'b1; rnw[0] = 1'b1; rd_data[0] = 8'hFF;
        step();
        req[0] = 1'b0;
        checks++;
        if (oe_o[0] !== 1'b1 || ack_o[0] !== 1'b1 || bus_obs[0] !== 8'hFF) begin
            errors++;
            $display("FAIL read0_drive oe=%b ack=%b bus=%h expected 1 1 ff", oe_o[0], ack_o[0], bus_obs[0]);
        end
        step();
        tb_en[0] = 1'b1; tb_dat[0] = 8'h00;
        #1;
        checks++;
        if (oe_o[0] !== 1'b0 || ack_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || bus_obs[0] !== 8'h00) begin
            errors++;
            $display("FAIL read0_idle oe=%b ack=%b busy=%b bus=%h expected 0 0 0 probe 00",
                     oe_o[0], ack_o[0], busy_o[0], bus_obs[0]);
        end
        tb_en[0] = 1'b0;
        req[0] = 1'b1; rnw[0] = 1'b1; rd_data[0] = 8'h81;
        step();
        req[0] = 1'b0;
        checks++;
        if (oe_o[0] !== 1'b1 || bus_obs[0] !== 8'h81) begin
            errors++;
            $display("FAIL read0_reaccept oe=%b bus=%h expected 1 81", oe_o[0], bus_obs[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req[1] = 1'b1; rnw[1] = 1'b1; rd_data[1] = 8'hC3;
        step();
        rnw[1] = 1'b0; tb_en[1] = 1'b1; tb_dat[1] = 8'h99;
        step();
        tb_en[1] = 1'b0;
        #1;
        checks++;
        if (oe_o[1] !== 1'b1 || bus_obs[1] !== 8'hC3 || wr_valid_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drive oe=%b bus=%h wrv=%b expected 1 c3 0", oe_o[1], bus_obs[1], wr_valid_o[1]);
        end
        step();
        tb_en[1] = 1'b1;
        checks++;
        if (wr_valid_o[1] !== 1'b0 || wr_data_o[1] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_ignore_a wrv=%b wr_data=%h expected 0 00", wr_valid_o[1], wr_data_o[1]);
        end
        step();
        req[1] = 1'b0; tb_en[1] = 1'b0;
        checks++;
        if (wr_valid_o[1] !== 1'b0 || ack_o[1] !== 1'b0 || wr_data_o[1] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_ignore_b wrv=%b ack=%b wr_data=%h expected 0 0 00",
                     wr_valid_o[1], ack_o[1], wr_data_o[1]);
        end
        req[1] = 1'b1; rnw[1] = 1'b0; tb_en[1] = 1'b1; tb_dat[1] = 8'h11;
        step();
        tb_dat[1] = 8'h22;
        checks++;
        if (wr_valid_o[1] !== 1'b1 || wr_data_o[1] !== 8'h11) begin
            errors++;
            $display("FAIL b2b_write1 wrv=%b wr_data=%h expected 1 11", wr_valid_o[1], wr_data_o[1]);
        end
        step();
        req[1] = 1'b0; tb_en[1] = 1'b0;
        checks++;
        if (wr_valid_o[1] !== 1'b1 || ack_o[1] !== 1'b1 || wr_data_o[1] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_write2 wrv=%b ack=%b wr_data=%h expected 1 1 22",
                     wr_valid_o[1], ack_o[1], wr_data_o[1]);
        end
        step();
        checks++;
        if (wr_valid_o[1] !== 1'b0 || ack_o[1] !== 1'b0 || wr_data_o[1] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_after wrv=%b ack=%b wr_data=%h expected 0 0 22",
                     wr_valid_o[1], ack_o[1], wr_data_o[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 600; it++) begin
            for (int g = 0; g < N; g++) begin
                rd_data[g] = 8'($urandom);
                if (exp_oe(g)) begin
                    tb_en[g] = 1'b0;
                    req[g]   = ($urandom_range(0, 3) == 0);
                    rnw[g]   = 1'b1;
                end else begin
                    tb_en[g]  = 1'b1;
                    tb_dat[g] = 8'($urandom);
                    req[g]    = ($urandom_range(0, 2) != 0);
                    rnw[g]    = 1'($urandom_range(0, 1));
                end
            end
            rst = ($urandom_range(0, 60) == 0);
            #1;
            for (int g = 0; g < N; g++) begin
                if (tb_en[g]) begin
                    checks++;
                    if (bus_obs[g] !== tb_dat[g]) begin
                        errors++;
                        $display("FAIL rnd_released g=%0d bus=%h expected bench value %h", g, bus_obs[g], tb_dat[g]);
                    end
                end
            end
            step();
            for (int g = 0; g < N; g++) begin
                if (exp_oe(g)) tb_en[g] = 1'b0;
            end
            #1;
            for (int g = 0; g < N; g++) begin
                checks++;
                if (oe_o[g] !== exp_oe(g)) begin
                    errors++;
                    $display("FAIL rnd_oe g=%0d cyc=%0d got %b expected %b", g, ed + 1, oe_o[g], exp_oe(g));
                end
                checks++;
                if (ack_o[g] !== (exp_oe(g) || exp_wrv(g))) begin
                    errors++;
                    $display("FAIL rnd_ack g=%0d cyc=%0d got %b expected %b", g, ed + 1, ack_o[g], exp_oe(g) || exp_wrv(g));
                end
                checks++;
                if (wr_valid_o[g] !== exp_wrv(g)) begin
                    errors++;
                    $display("FAIL rnd_wrv g=%0d cyc=%0d got %b expected %b", g, ed + 1, wr_valid_o[g], exp_wrv(g));
                end
                checks++;
                if (busy_o[g] !== exp_busy(g)) begin
                    errors++;
                    $display("FAIL rnd_busy g=%0d cyc=%0d got %b expected %b", g, ed + 1, busy_o[g], exp_busy(g));
                end
                checks++;
                if (wr_data_o[g] !== m_wr[g]) begin
                    errors++;
                    $display("FAIL rnd_wr_data g=%0d cyc=%0d got %h expected %h", g, ed + 1, wr_data_o[g], m_wr[g]);
                end
                if (exp_oe(g)) begin
                    checks++;
                    if (bus_obs[g] !== m_drv[g]) begin
                        errors++;
                        $display("FAIL rnd_drive g=%0d cyc=%0d bus=%h expected %h", g, ed + 1, bus_obs[g], m_drv[g]);
                    end
                end
            end
        end
        rst = 1'b0; req = '0; tb_en = '0;
        step();
        step();
    endtask

    task automatic test_contention();
        checks++;
        if (contention !== 0) begin
            errors++;
            $display("FAIL contention events=%0d expected 0", contention);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_turn1();
        test_read_turn0();
        test_back_to_back();
        test_random();
        test_contention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
